// File: rtl/fadd_share_if.sv
// Bundle between the shared-adder scheduler, its requesters, the result consumer and the adder.
// Handshakes: a requester holds req with stable operands until gnt pulses for one cycle, which
// means the request is accepted. A result moves on a cycle where rsp_valid && rsp_ready. Once
// rsp_valid is high it stays high, with rsp_id/rsp_z/rsp_ovf stable, until that cycle.
interface fadd_share_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]      req;
  logic [N-1:0]      req_sub;
  logic [32*N-1:0]   req_x;
  logic [32*N-1:0]   req_y;
  logic [N-1:0]      gnt;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_z;
  logic [1:0]        rsp_ovf;
  logic              rsp_ready;
  logic [31:0]       add_x;
  logic [31:0]       add_y;
  logic              add_enable;
  logic [31:0]       add_z;
  logic [1:0]        add_overflow;

  modport slave (
    input  req, req_sub, req_x, req_y, rsp_ready, add_z, add_overflow,
    output gnt, rsp_valid, rsp_id, rsp_z, rsp_ovf, add_x, add_y, add_enable
  );

  modport master (
    output req, req_sub, req_x, req_y, rsp_ready, add_z, add_overflow,
    input  gnt, rsp_valid, rsp_id, rsp_z, rsp_ovf, add_x, add_y, add_enable
  );
endinterface

// File: rtl/fadd_share_ctrl.sv
// Time-shares one fixed-latency float adder among N requesters: round-robin grant, operand
// latch (subtract becomes add with y's sign flipped), timed enable, then a held response.
module fadd_share_ctrl #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int ADD_LAT = 6
) (
  input  logic             clk,
  input  logic             rst,
  fadd_share_if.slave      bus,
  output logic [1:0]       dbg_state
);
  localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ADD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] last;
  logic [IDW-1:0] id;
  logic [IDW-1:0] win;
  logic           found;
  logic [N-1:0]   gnt_c;
  logic [31:0]    x_r;
  logic [31:0]    y_r;
  logic [31:0]    z_r;
  logic [1:0]     ovf_r;
  logic [IDW-1:0] rsp_id_r;
  logic [31:0]    x_arr [N];
  logic [31:0]    y_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign x_arr[i] = bus.req_x[32*i +: 32];
    assign y_arr[i] = bus.req_y[32*i +: 32];
  end

  // Round-robin: rotate req so the slot after 'last' sits at bit 0, take the lowest set bit,
  // then map the offset back to an absolute index (mod N, N need not be a power of two).
  logic [N-1:0] rot;
  logic [IDW:0] start;
  logic [IDW:0] off;
  logic [IDW:0] sum;

  always_comb begin
    start = {1'b0, last} + 1'b1;
    rot   = N'({bus.req, bus.req} >> start);
    off   = '0;
    found = 1'b0;
    for (int i = N-1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = (IDW+1)'(i);
        found = 1'b1;
      end
    end
    sum = start + off;
    if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
    win = sum[IDW-1:0];
  end

  always_comb begin
    state_nxt = state;
    gnt_c     = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          gnt_c     = N'(1) << win;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_LAST) state_nxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A cycle with rst high never accepts a request.
    if (rst) gnt_c = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= IDW'(N - 1);
      id       <= '0;
      x_r      <= '0;
      y_r      <= '0;
      z_r      <= '0;
      ovf_r    <= '0;
      rsp_id_r <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (found) begin
            x_r  <= x_arr[win];
            y_r  <= {y_arr[win][31] ^ bus.req_sub[win], y_arr[win][30:0]};
            id   <= win;
            last <= win;
            cnt  <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            z_r      <= bus.add_z;
            ovf_r    <= bus.add_overflow;
            rsp_id_r <= id;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt        = gnt_c;
  assign bus.add_enable = (state == RUN);
  assign bus.rsp_valid  = (state == RESP);
  assign bus.add_x      = x_r;
  assign bus.add_y      = y_r;
  assign bus.rsp_z      = z_r;
  assign bus.rsp_ovf    = ovf_r;
  assign bus.rsp_id     = rsp_id_r;
  assign dbg_state      = state;
endmodule

// File: tb/tb_fadd_share_ctrl.sv
// Bench for fadd_share_ctrl: behavioural adder with a real latency window, a transaction-level
// reference (round-robin pick, timer, expected response queue), directed cases then random traffic.
module tb_fadd_share_ctrl;
  localparam int N       = 4;
  localparam int IDW     = 2;
  localparam int ADD_LAT = 6;
  localparam int RW      = IDW + 34;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fadd_share_if #(.N(N), .IDW(IDW)) bus();

  fadd_share_ctrl #(.N(N), .IDW(IDW), .ADD_LAT(ADD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Stand-in float adder: exact answers for the known operand pairs, a deterministic mix otherwise.
  function automatic logic [33:0] fadd_fn(input logic [31:0] x, input logic [31:0] y);
    if (x == 32'h40000000 && y == 32'h3F800000) return {2'b00, 32'h40400000};
    if (x == 32'h41A3C28F && y == 32'h42B5999A) return {2'b00, 32'h42DE8A3D};
    if (x == 32'h7F7FFFFF && y == 32'h7F7FFFFF) return {2'b01, 32'h7F800000};
    return {(x[0] ^ y[0]) ? 2'b01 : ((x[1] & y[1]) ? 2'b10 : 2'b00), (x + y) ^ {y[15:0], x[31:16]}};
  endfunction

  // Adder result is only meaningful once enable has been high for ADD_LAT cycles.
  int          en_cnt = 0;
  logic [33:0] add_res;
  always @(posedge clk) en_cnt <= bus.add_enable ? en_cnt + 1 : 0;
  assign add_res          = fadd_fn(bus.add_x, bus.add_y);
  assign bus.add_z        = (bus.add_enable && en_cnt >= ADD_LAT-1) ? add_res[31:0]  : 32'hDEADBEEF;
  assign bus.add_overflow = (bus.add_enable && en_cnt >= ADD_LAT-1) ? add_res[33:32] : 2'b11;

  // Reference model
  int              m_last   = N-1;
  bit              m_active = 1'b0;
  int              m_age    = 0;
  logic [31:0]     m_x      = '0;
  logic [31:0]     m_y      = '0;
  logic [RW-1:0]   exp_q[$];

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0]  exp_gnt;
    logic [31:0]   yv;
    logic [RW-1:0] e;
    int            w;
    exp_gnt = '0;
    w = -1;
    if (!m_active && !rst) begin
      w = rr_pick(bus.req, m_last);
      if (w >= 0) exp_gnt[w] = 1'b1;
    end
    check("gnt", 64'(bus.gnt), 64'(exp_gnt));
    check("add_enable", 64'(bus.add_enable), 64'(m_active && m_age >= 1 && m_age <= ADD_LAT));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(m_active && m_age > ADD_LAT));
    check("add_x", 64'(bus.add_x), 64'(m_x));
    check("add_y", 64'(bus.add_y), 64'(m_y));
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 64'(1), 64'(0));
      else begin
        e = exp_q[0];
        check("rsp_id", 64'(bus.rsp_id), 64'(e[RW-1:34]));
        check("rsp_ovf", 64'(bus.rsp_ovf), 64'(e[33:32]));
        check("rsp_z", 64'(bus.rsp_z), 64'(e[31:0]));
      end
    end
    if (rst) begin
      m_active = 1'b0;
      m_last   = N-1;
      m_x      = '0;
      m_y      = '0;
      exp_q.delete();
    end else if (w >= 0) begin
      yv       = bus.req_y[32*w +: 32];
      yv[31]   = yv[31] ^ bus.req_sub[w];
      m_active = 1'b1;
      m_age    = 1;
      m_last   = w;
      m_x      = bus.req_x[32*w +: 32];
      m_y      = yv;
      exp_q.push_back({IDW'(w), fadd_fn(m_x, m_y)});
    end else if (m_active) begin
      if (m_age > ADD_LAT && bus.rsp_ready) begin
        m_active = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        m_age++;
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic sub, input logic [31:0] x, input logic [31:0] y);
    bus.req_x[32*i +: 32] = x;
    bus.req_y[32*i +: 32] = y;
    bus.req_sub[i]        = sub;
    bus.req[i]            = 1'b1;
  endtask

  task automatic wait_gnt(input int budget, output logic [N-1:0] g, output int at);
    g  = '0;
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        g  = bus.gnt;
        at = cyc;
        return;
      end
    end
    check("gnt_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_valid(input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        at = cyc;
        return;
      end
    end
    check("valid_timeout", 64'(0), 64'(1));
  endtask

  task automatic pulse_rst();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] gs;
    logic [31:0]  z0;
    int           t0, t1, tp;
    bus.req       = '0;
    bus.req_sub   = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_enable", 64'(bus.add_enable), 64'(0));
    check("rst_rsp_z", 64'(bus.rsp_z), 64'(0));
    check("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
    check("rst_rsp_ovf", 64'(bus.rsp_ovf), 64'(0));

    // Single add
    tick();
    set_req(0, 1'b0, 32'h40000000, 32'h3F800000);
    wait_gnt(20, g, t0);
    check("t1_gnt", 64'(g), 64'(4'b0001));
    tick();
    bus.req = '0;
    wait_valid(20, t1);
    check("t1_latency", 64'(t1 - t0), 64'(ADD_LAT + 1));
    check("t1_z", 64'(bus.rsp_z), 64'(32'h40400000));
    check("t1_id", 64'(bus.rsp_id), 64'(0));
    check("t1_ovf", 64'(bus.rsp_ovf), 64'(0));

    // Subtract
    tick();
    set_req(1, 1'b1, 32'h41A3C28F, 32'hC2B5999A);
    wait_gnt(20, g, t0);
    check("t2_gnt", 64'(g), 64'(4'b0010));
    tick();
    bus.req = '0;
    @(negedge clk);
    check("t2_add_y", 64'(bus.add_y), 64'(32'h42B5999A));
    wait_valid(20, t1);
    check("t2_z", 64'(bus.rsp_z), 64'(32'h42DE8A3D));
    check("t2_id", 64'(bus.rsp_id), 64'(1));

    // Fairness with all four requesting
    pulse_rst();
    for (int i = 0; i < N; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom(), $urandom());
    tp = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(20, g, t0);
      gs = 4'b0001 << (k % 4);
      check("t3_gnt", 64'(g), 64'(gs));
      if (k > 0) check("t3_gap", 64'(t0 - tp), 64'(ADD_LAT + 2));
      tp = t0;
    end
    tick();
    bus.req = '0;

    // Backpressure
    pulse_rst();
    set_req(0, 1'b0, $urandom(), $urandom());
    wait_gnt(20, g, t0);
    tick();
    bus.req       = '0;
    bus.rsp_ready = 1'b0;
    set_req(2, 1'b0, $urandom(), $urandom());
    wait_valid(20, t1);
    z0 = bus.rsp_z;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("t4_hold_valid", 64'(bus.rsp_valid), 64'(1));
      check("t4_hold_z", 64'(bus.rsp_z), 64'(z0));
      check("t4_no_gnt", 64'(bus.gnt), 64'(0));
    end
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_hs_valid", 64'(bus.rsp_valid), 64'(1));
    @(negedge clk);
    check("t4_gnt2", 64'(bus.gnt), 64'(4'b0100));
    tick();
    bus.req = '0;
    wait_valid(20, t1);

    // Reset in the middle of RUN
    pulse_rst();
    set_req(2, 1'b0, 32'h12345678, 32'h0BADF00D);
    wait_gnt(20, g, t0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_enable", 64'(bus.add_enable), 64'(0));
    check("t5_valid", 64'(bus.rsp_valid), 64'(0));
    check("t5_add_x", 64'(bus.add_x), 64'(0));
    check("t5_rsp_z", 64'(bus.rsp_z), 64'(0));
    check("t5_gnt2", 64'(bus.gnt), 64'(4'b0100));
    tick();
    rst = 1'b1;
    set_req(0, 1'b1, $urandom(), $urandom());
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_gnt0", 64'(bus.gnt), 64'(4'b0001));
    tick();
    bus.req = '0;
    wait_valid(20, t1);

    // Overflow pass-through
    tick();
    set_req(3, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF);
    wait_gnt(20, g, t0);
    tick();
    bus.req = '0;
    wait_valid(20, t1);
    check("t6_z", 64'(bus.rsp_z), 64'(32'h7F800000));
    check("t6_ovf", 64'(bus.rsp_ovf), 64'(2'b01));

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = bus.gnt;
      tick();
      rst           = ($urandom_range(0, 299) == 0);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (bus.req[i]) begin
          if (g[i]) begin
            if ($urandom_range(0, 1) == 1) bus.req[i] = 1'b0;
          end else if ($urandom_range(0, 15) == 0) begin
            bus.req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(i, 1'($urandom_range(0, 1)), $urandom(), $urandom());
        end
      end
    end
    tick();
    rst           = 1'b0;
    bus.req       = '0;
    bus.rsp_ready = 1'b1;
    repeat (20) tick();
    check("drain", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
